// File: rtl/frame_uart_tx.sv
// rtl/frame_uart_tx.sv - frame-buffer read-back transmitter, 8N1 UART, LSB first
module frame_uart_tx #(
    parameter int BAUD_CNT_END = 433,
    parameter int FRAME_BYTES  = 40000,
    parameter int ADDR_W       = 16
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (BAUD_CNT_END > 0) ? $clog2(BAUD_CNT_END + 1) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_END);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [BAUD_W-1:0]   baud_cnt, baud_cnt_nxt;
    logic [3:0]          bit_cnt, bit_cnt_nxt;
    logic [9:0]          shift, shift_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt;
    logic                tx_nxt, busy_nxt, done_nxt;

    // State register; reset drops straight back to IDLE, abandoning any partial byte.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        rd_addr_nxt  = rd_addr;
        tx_nxt       = tx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (start) begin
                    state_nxt   = FETCH;
                    rd_addr_nxt = '0;
                    busy_nxt    = 1'b1;
                end
            end
            FETCH: begin
                // rd_addr is presented this cycle; read data lands next cycle.
                tx_nxt    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                // Frame is {stop, data, start}; shifting right exposes bits in wire order.
                shift_nxt    = {1'b1, rd_data, 1'b0};
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                tx_nxt       = 1'b0;
                state_nxt    = SEND;
            end
            SEND: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_nxt = '0;
                    if (bit_cnt == 4'd9) begin
                        // Stop bit has run its full time; line is already high.
                        bit_cnt_nxt = '0;
                        tx_nxt      = 1'b1;
                        if (rd_addr == ADDR_LAST) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            rd_addr_nxt = rd_addr + ADDR_W'(1);
                            state_nxt   = FETCH;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        shift_nxt   = {1'b1, shift[9:1]};
                        tx_nxt      = shift[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DONE: begin
                // start is deliberately not sampled here; it is neither taken nor queued.
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and datapath; asynchronous reset forces tx high and busy low at once.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rd_addr  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            rd_addr  <= rd_addr_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule
